// File: rtl/pkt_fifo_pkg.sv
// pkt_fifo shared types: write-side FSM states, stats width and
// the pointer-wrap helper used for non-power-of-two depths.
package pkt_fifo_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_PKT,
    WR_DISCARD
  } wr_state_t;

  localparam int DROP_CNT_W = 16;

  function automatic int ptr_inc(input int p, input int depth);
    return (p == depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle with valid/ready handshake.
// sink faces the producer, source faces the consumer.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 4
);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW =
    (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [DW-1:0] data;
  logic [EW-1:0] empty;
  logic          vld;
  logic          rdy;
  logic          sop;
  logic          eop;

  modport sink (
    input  data, empty, vld, sop, eop,
    output rdy
  );

  modport source (
    output data, empty, vld, sop, eop,
    input  rdy
  );
endinterface

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port register array: one synchronous write port,
// one combinational read port (first-word-fall-through).
module pkt_fifo_ram
  import pkt_fifo_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pkt_fifo.sv
// Avalon-ST packet FIFO with committed/speculative write pointers.
// PKT_FIFO_STATS_EN adds the saturating drop_count output.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH_IN_BYTES = 4,
  parameter int FIFO_DEPTH          = 16,
  parameter bit STORE_FORWARD       = 1'b1,
  parameter bit ERROR_DROP          = 1'b1,
  parameter int AF_THRESH           = FIFO_DEPTH - 2,
  parameter int AE_THRESH           = 2,
  localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  avalon_st_if.sink      write,
  input  logic           write_error,
  avalon_st_if.source    read,
  output logic [CW-1:0]  fill_level,
  output logic [CW-1:0]  pkt_count,
  output logic           full,
  output logic           empty,
  output logic           almost_full,
  output logic           almost_empty
`ifdef PKT_FIFO_STATS_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int DW = 8 * DATA_WIDTH_IN_BYTES;
  localparam int EW =
    (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;
  localparam int MW = DW + EW + 2;

  if (ERROR_DROP && !STORE_FORWARD) begin : g_cfg_err
    $error("pkt_fifo: ERROR_DROP needs STORE_FORWARD");
  end

  wr_state_t     st_q, st_d;
  logic [PW-1:0] wr_q, wr_d, cm_q, cm_d, rd_q, rd_d, wbase;
  logic [CW-1:0] fill_q, fill_d, pkt_q, pkt_d, unc_q, unc_d;
  logic          wr_fire, pop, pop_eop, err;
  logic          we, commit, drop, rb;
  logic [MW-1:0] wentry, rentry;

  assign full         = fill_q == CW'(FIFO_DEPTH);
  assign empty        = fill_q == '0;
  assign almost_full  = fill_q >= CW'(AF_THRESH);
  assign almost_empty = fill_q <= CW'(AE_THRESH);
  assign fill_level   = fill_q;
  assign pkt_count    = pkt_q;

  assign write.rdy = (st_q == WR_DISCARD) || !full;
  assign wr_fire   = write.vld && write.rdy;
  assign err       = ERROR_DROP && write.eop && write_error;

  assign read.vld = STORE_FORWARD ?
    ((cm_q != rd_q) || (pkt_q != '0)) : !empty;
  assign pop      = read.vld && read.rdy;
  assign pop_eop  = pop && rentry[0];

  // Rollback rewinds to the last packet boundary before writing.
  always_comb begin
    st_d   = st_q;
    we     = 1'b0;
    commit = 1'b0;
    drop   = 1'b0;
    rb     = 1'b0;
    if (!STORE_FORWARD) begin
      we     = wr_fire;
      commit = wr_fire && write.eop;
      if (wr_fire) st_d = write.eop ? WR_IDLE : WR_PKT;
    end else begin
      unique case (st_q)
        WR_IDLE: if (wr_fire && write.sop) begin
          we     = !err;
          drop   = err;
          commit = !err && write.eop;
          st_d   = write.eop ? WR_IDLE : WR_PKT;
        end
        WR_PKT: if (wr_fire) begin
          rb     = write.sop || err;
          drop   = write.sop || err;
          we     = !err;
          commit = !err && write.eop;
          if (write.eop) st_d = WR_IDLE;
        end else if (full && pkt_q == '0) begin
          rb   = 1'b1;
          drop = 1'b1;
          st_d = WR_DISCARD;
        end
        WR_DISCARD: if (wr_fire && write.eop) st_d = WR_IDLE;
        default: st_d = WR_IDLE;
      endcase
    end
  end

  assign wbase = rb ? cm_q : wr_q;
  assign wr_d  = we ? PW'(ptr_inc(int'(wbase), FIFO_DEPTH)) : wbase;
  assign cm_d  = commit ? wr_d : cm_q;
  assign rd_d  = pop ? PW'(ptr_inc(int'(rd_q), FIFO_DEPTH)) : rd_q;

  assign fill_d = fill_q - (rb ? unc_q : '0)
                + CW'(we) - CW'(pop);
  assign pkt_d  = pkt_q + CW'(commit) - CW'(pop_eop);
  assign unc_d  = (commit || !STORE_FORWARD) ? '0 :
                  (rb ? '0 : unc_q) + CW'(we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= WR_IDLE;
      wr_q   <= '0;
      cm_q   <= '0;
      rd_q   <= '0;
      fill_q <= '0;
      pkt_q  <= '0;
      unc_q  <= '0;
    end else begin
      st_q   <= st_d;
      wr_q   <= wr_d;
      cm_q   <= cm_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      pkt_q  <= pkt_d;
      unc_q  <= unc_d;
    end
  end

  assign wentry = {write.data, write.empty, write.sop, write.eop};
  assign {read.data, read.empty, read.sop, read.eop} = rentry;

  pkt_fifo_ram #(
    .W     (MW),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wbase),
    .wdata_i (wentry),
    .raddr_i (rd_q),
    .rdata_o (rentry)
  );

`ifdef PKT_FIFO_STATS_EN
  logic [DROP_CNT_W-1:0] drop_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   drop_q <= '0;
    else if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
  end

  assign drop_count = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo: store-and-forward (depth 16 and 4)
// and cut-through (depth 5) instances sharing one clock and reset.
module tb_pkt_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) w16(), r16();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) w4(), r4();
  avalon_st_if #(.DATA_WIDTH_IN_BYTES(4)) w5(), r5();

  logic er16 = 1'b0, er4 = 1'b0, er5 = 1'b0;
  logic [4:0] fl16, pc16;
  logic [2:0] fl4, pc4, fl5, pc5;
  logic fu16, em16, af16, ae16;
  logic fu4, em4, af4, ae4;
  logic fu5, em5, af5, ae5;
`ifdef PKT_FIFO_STATS_EN
  logic [15:0] dc16, dc4, dc5;
`endif

  pkt_fifo #(.FIFO_DEPTH(16)) u_sf16 (
    .clk(clk), .rst_n(rst_n), .write(w16), .write_error(er16),
    .read(r16), .fill_level(fl16), .pkt_count(pc16),
    .full(fu16), .empty(em16),
    .almost_full(af16), .almost_empty(ae16)
`ifdef PKT_FIFO_STATS_EN
    , .drop_count(dc16)
`endif
  );

  pkt_fifo #(.FIFO_DEPTH(4)) u_sf4 (
    .clk(clk), .rst_n(rst_n), .write(w4), .write_error(er4),
    .read(r4), .fill_level(fl4), .pkt_count(pc4),
    .full(fu4), .empty(em4),
    .almost_full(af4), .almost_empty(ae4)
`ifdef PKT_FIFO_STATS_EN
    , .drop_count(dc4)
`endif
  );

  pkt_fifo #(
    .FIFO_DEPTH(5), .STORE_FORWARD(1'b0), .ERROR_DROP(1'b0)
  ) u_ct5 (
    .clk(clk), .rst_n(rst_n), .write(w5), .write_error(er5),
    .read(r5), .fill_level(fl5), .pkt_count(pc5),
    .full(fu5), .empty(em5),
    .almost_full(af5), .almost_empty(ae5)
`ifdef PKT_FIFO_STATS_EN
    , .drop_count(dc5)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int u, input logic v, input logic s,
                       input logic e, input logic er,
                       input logic [31:0] d);
    case (u)
      0: begin
        w16.vld = v; w16.sop = s; w16.eop = e;
        w16.data = d; w16.empty = '0; er16 = er;
      end
      1: begin
        w4.vld = v; w4.sop = s; w4.eop = e;
        w4.data = d; w4.empty = '0; er4 = er;
      end
      default: begin
        w5.vld = v; w5.sop = s; w5.eop = e;
        w5.data = d; w5.empty = '0; er5 = er;
      end
    endcase
  endtask

  function automatic logic wrdy(input int u);
    case (u)
      0:       return w16.rdy;
      1:       return w4.rdy;
      default: return w5.rdy;
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call aligned just after a rising edge; returns just after the
  // edge that accepted the beat.
  task automatic put(input int u, input logic s, input logic e,
                     input logic er, input logic [31:0] d);
    int n = 0;
    drive(u, 1'b1, s, e, er, d);
    @(negedge clk);
    while (!wrdy(u) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wrdy(u)) check("put_rdy", 32'(wrdy(u)), 1);
    sync();
    drive(u, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  int   q5[$];
  int   mfill = 0;
  bit   mon5 = 1'b0;
  bit   tog5 = 1'b0;
  bit   saw_full = 1'b0;

  always @(posedge clk) begin
    #1;
    if (tog5) r5.rdy = ~r5.rdy;
  end

  always @(negedge clk) begin
    if (mon5) begin
      check("ct_fill", 32'(fl5), mfill);
      check("ct_full", 32'(fu5), 32'(mfill == 5));
      check("ct_wrdy", 32'(w5.rdy), 32'(mfill != 5));
      check("ct_vld", 32'(r5.vld), 32'(mfill != 0));
      if (mfill == 5) saw_full = 1'b1;
      if (r5.vld && r5.rdy) q5.push_back(int'(r5.data));
      mfill = mfill + int'(w5.vld && w5.rdy)
                    - int'(r5.vld && r5.rdy);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0, 0);
    r16.rdy = 1'b0;
    r4.rdy  = 1'b0;
    r5.rdy  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fill", 32'(fl16), 0);
    check("rst_pkt", 32'(pc16), 0);
    check("rst_empty", 32'(em16), 1);
    check("rst_full", 32'(fu16), 0);
    check("rst_ae", 32'(ae16), 1);
    check("rst_af", 32'(af16), 0);
    check("rst_vld", 32'(r16.vld), 0);
    check("rst_wrdy", 32'(w16.rdy), 1);
    check("rst_ct_vld", 32'(r5.vld), 0);
    rst_n = 1'b1;
    sync();

    // 3-beat packet, store-and-forward
    r16.rdy = 1'b1;
    put(0, 1, 0, 0, 'h11);
    put(0, 0, 0, 0, 'h22);
    @(negedge clk);
    check("sf_hold_vld", 32'(r16.vld), 0);
    check("sf_hold_fill", 32'(fl16), 2);
    check("sf_hold_pkt", 32'(pc16), 0);
    sync();
    put(0, 0, 1, 0, 'h33);
    @(negedge clk);
    check("sf_vld", 32'(r16.vld), 1);
    check("sf_d0", r16.data, 'h11);
    check("sf_sop", 32'(r16.sop), 1);
    check("sf_pkt1", 32'(pc16), 1);
    @(negedge clk);
    check("sf_d1", r16.data, 'h22);
    @(negedge clk);
    check("sf_d2", r16.data, 'h33);
    check("sf_eop", 32'(r16.eop), 1);
    @(negedge clk);
    check("sf_vld_end", 32'(r16.vld), 0);
    check("sf_pkt0", 32'(pc16), 0);
    check("sf_fill0", 32'(fl16), 0);

    // errored packet is dropped
    sync();
    put(0, 1, 0, 0, 'h51);
    put(0, 0, 0, 0, 'h52);
    put(0, 0, 0, 0, 'h53);
    @(negedge clk);
    check("err_fill3", 32'(fl16), 3);
    check("err_vld0", 32'(r16.vld), 0);
    sync();
    put(0, 0, 1, 1, 'h54);
    @(negedge clk);
    check("err_fill", 32'(fl16), 0);
    check("err_vld", 32'(r16.vld), 0);
    check("err_pkt", 32'(pc16), 0);
`ifdef PKT_FIFO_STATS_EN
    check("err_drop", 32'(dc16), 1);
`endif

    // sop restart drops the partial packet
    sync();
    put(0, 1, 0, 0, 'hA1);
    @(negedge clk);
    check("rs_fill1", 32'(fl16), 1);
    sync();
    put(0, 1, 0, 0, 'hB1);
    @(negedge clk);
    check("rs_fill", 32'(fl16), 1);
    check("rs_vld0", 32'(r16.vld), 0);
`ifdef PKT_FIFO_STATS_EN
    check("rs_drop", 32'(dc16), 2);
`endif
    sync();
    put(0, 0, 1, 0, 'hB2);
    @(negedge clk);
    check("rs_vld", 32'(r16.vld), 1);
    check("rs_d0", r16.data, 'hB1);
    check("rs_sop", 32'(r16.sop), 1);
    @(negedge clk);
    check("rs_d1", r16.data, 'hB2);
    check("rs_eop", 32'(r16.eop), 1);
    @(negedge clk);
    check("rs_end", 32'(r16.vld), 0);
    check("rs_fill0", 32'(fl16), 0);

    // oversize packet on depth 4, consumer stalled
    sync();
    for (int i = 1; i <= 4; i++) put(1, i == 1, 0, 0, i);
    @(negedge clk);
    check("os_fill4", 32'(fl4), 4);
    check("os_full", 32'(fu4), 1);
    check("os_wrdy0", 32'(w4.rdy), 0);
    check("os_af", 32'(af4), 1);
    check("os_ae", 32'(ae4), 0);
    check("os_vld0", 32'(r4.vld), 0);
    @(negedge clk);
    check("os_fill0", 32'(fl4), 0);
    check("os_full0", 32'(fu4), 0);
    check("os_wrdy1", 32'(w4.rdy), 1);
    sync();
    put(1, 0, 0, 0, 5);
    put(1, 0, 1, 0, 6);
    @(negedge clk);
    check("os_disc_fill", 32'(fl4), 0);
    check("os_disc_pkt", 32'(pc4), 0);
    sync();
    put(1, 1, 0, 0, 'h41);
    put(1, 0, 1, 0, 'h42);
    @(negedge clk);
    check("os_nx_fill", 32'(fl4), 2);
    check("os_nx_pkt", 32'(pc4), 1);
    check("os_nx_vld", 32'(r4.vld), 1);
    sync();
    r4.rdy = 1'b1;
    @(negedge clk);
    check("os_nx_d0", r4.data, 'h41);
    @(negedge clk);
    check("os_nx_d1", r4.data, 'h42);
    check("os_nx_eop", 32'(r4.eop), 1);
    @(negedge clk);
    check("os_nx_end", 32'(r4.vld), 0);
    check("os_nx_pkt0", 32'(pc4), 0);
`ifdef PKT_FIFO_STATS_EN
    check("os_drop", 32'(dc4), 1);
`endif
    r4.rdy = 1'b0;

    // cut-through, depth 5, toggling consumer
    check("ct_start", 32'(fl5), 0);
    sync();
    mon5 = 1'b1;
    tog5 = 1'b1;
    for (int i = 1; i <= 12; i++) put(2, i == 1, i == 12, 0, i);
    for (int n = 0; n < 100 && q5.size() < 12; n++) sync();
    mon5 = 1'b0;
    tog5 = 1'b0;
    check("ct_count", q5.size(), 12);
    for (int i = 0; i < q5.size(); i++)
      check("ct_order", q5[i], i + 1);
    check("ct_saw_full", 32'(saw_full), 1);

    // reset mid-packet
    sync();
    r16.rdy = 1'b0;
    put(0, 1, 0, 0, 'hC1);
    put(0, 0, 0, 0, 'hC2);
    put(0, 0, 0, 0, 'hC3);
    @(negedge clk);
    check("rm_fill3", 32'(fl16), 3);
    rst_n = 1'b0;
    #1;
    check("rm_fill", 32'(fl16), 0);
    check("rm_empty", 32'(em16), 1);
    check("rm_vld", 32'(r16.vld), 0);
    @(negedge clk);
    rst_n = 1'b1;
    r16.rdy = 1'b1;
    @(negedge clk);
    check("rm_vld_after", 32'(r16.vld), 0);
    check("rm_fill_after", 32'(fl16), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
